// File: rtl/aes_key_schedule.sv
// AES-128 round-key generator: expands a cipher key into 11 round keys, one per clock,
// and presents the key chosen by round_sel in encryption or decryption order.
module aes_key_schedule #(
    parameter int unsigned INVERSE_ORDER = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] cipher_key,
    input  logic [3:0]   round_sel,
    output logic [127:0] round_key,
    output logic         key_valid,
    output logic         busy
);

    localparam int unsigned NR     = 10;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [3:0]       r_q, r_d;
    logic [KEY_W-1:0] rk_q [NR+1];
    logic [KEY_W-1:0] rk_d [NR+1];
    logic             key_valid_q, key_valid_d;
    logic             busy_q, busy_d;

    logic [3:0]        prev_idx;
    logic [KEY_W-1:0]  prev_key;
    logic [WORD_W-1:0] t_word, q0, q1, q2, q3;

    // One expansion step: derive rk[r] from rk[r-1].
    always_comb begin
        prev_idx = (r_q == 4'd0) ? 4'd0 : 4'(r_q - 4'd1);
        prev_key = rk_q[prev_idx];
        t_word   = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon(r_q), 24'h0};
        q0       = prev_key[127:96] ^ t_word;
        q1       = q0 ^ prev_key[95:64];
        q2       = q1 ^ prev_key[63:32];
        q3       = q2 ^ prev_key[31:0];
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        rk_d        = rk_q;
        key_valid_d = key_valid_q;
        busy_d      = busy_q;
        if (key_load) begin
            // A load in any state discards whatever expansion was in flight.
            state_d     = ST_EXPAND;
            r_d         = 4'd1;
            rk_d[0]     = cipher_key;
            key_valid_d = 1'b0;
            busy_d      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_EXPAND: begin
                    rk_d[r_q] = {q0, q1, q2, q3};
                    r_d       = 4'(r_q + 4'd1);
                    if (r_q >= 4'(NR)) begin
                        state_d     = ST_DONE;
                        key_valid_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
                ST_DONE: ;
                default: begin
                    state_d     = ST_IDLE;
                    key_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            r_q         <= 4'd0;
            rk_q        <= '{default: '0};
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            rk_q        <= rk_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Read mux: zero for selects past the last round.
    always_comb begin
        round_key = '0;
        if (round_sel <= 4'(NR)) begin
            if (INVERSE_ORDER != 0) begin
                round_key = rk_q[4'(4'(NR) - round_sel)];
            end else begin
                round_key = rk_q[round_sel];
            end
        end
    end

    assign key_valid = key_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: both read orders against a GF(2^8)-derived FIPS-197 key expansion model.
`timescale 1ns/1ps
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_load;
    logic [127:0] cipher_key;
    logic [3:0]   round_sel;
    logic [127:0] rk_inv, rk_fwd;
    logic         valid_inv, valid_fwd, busy_inv, busy_fwd;

    int total = 0;
    int bad   = 0;

    logic [127:0] ref_rk [11];
    logic [127:0] exp_inv, exp_fwd;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_schedule #(.INVERSE_ORDER(1)) u_dut_inv (
        .clk(clk), .reset(reset), .key_load(key_load), .cipher_key(cipher_key),
        .round_sel(round_sel), .round_key(rk_inv), .key_valid(valid_inv), .busy(busy_inv)
    );

    aes_key_schedule #(.INVERSE_ORDER(0)) u_dut_fwd (
        .clk(clk), .reset(reset), .key_load(key_load), .cipher_key(cipher_key),
        .round_sel(round_sel), .round_key(rk_fwd), .key_valid(valid_fwd), .busy(busy_fwd)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gf_mul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])}
                      ^ {rc, 24'h0};
                rc  = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 11; k++) ref_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic model_clear();
        for (int k = 0; k < 11; k++) ref_rk[k] = '0;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at a negedge; key_load is sampled on the following posedge.
    task automatic do_load(input logic [127:0] key);
        cipher_key = key;
        key_load   = 1'b1;
        @(negedge clk);
        key_load   = 1'b0;
        cipher_key = rand_key();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_inv && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; key_load = 1'b0; cipher_key = '0; round_sel = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total += 2;
        if (busy_inv !== 1'b0 || busy_fwd !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b/%b exp=0", busy_inv, busy_fwd);
        end
        if (valid_inv !== 1'b0 || valid_fwd !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b/%b exp=0", valid_inv, valid_fwd);
        end
        for (int s = 0; s < 16; s++) begin
            @(negedge clk); round_sel = 4'(s); #1;
            total++;
            if (rk_inv !== '0 || rk_fwd !== '0) begin
                bad++; $display("FAIL reset_key sel=%0d got=%h/%h exp=0", s, rk_inv, rk_fwd);
            end
        end
    endtask

    task automatic test_fips();
        int n;
        @(negedge clk);
        do_load(FIPS_KEY);
        total += 2;
        if (busy_inv !== 1'b1 || valid_inv !== 1'b0) begin
            bad++; $display("FAIL fips_start busy=%b valid=%b exp busy=1 valid=0", busy_inv, valid_inv);
        end
        wait_valid(n);
        if (n != 10) begin bad++; $display("FAIL fips_latency got=%0d exp=10", n); end
        total += 2;
        if (busy_inv !== 1'b0) begin bad++; $display("FAIL fips_done_busy got=%b exp=0", busy_inv); end
        if (valid_fwd !== 1'b1) begin bad++; $display("FAIL fips_fwd_valid got=%b exp=1", valid_fwd); end
        round_sel = 4'd0; #1; total++;
        if (rk_inv !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++; $display("FAIL fips_inv0 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", rk_inv);
        end
        round_sel = 4'd9; #1; total++;
        if (rk_inv !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            bad++; $display("FAIL fips_inv9 got=%h exp=a0fafe1788542cb123a339392a6c7605", rk_inv);
        end
        round_sel = 4'd10; #1; total += 2;
        if (rk_inv !== FIPS_KEY) begin bad++; $display("FAIL fips_inv10 got=%h exp=%h", rk_inv, FIPS_KEY); end
        if (rk_fwd !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++; $display("FAIL fips_fwd10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", rk_fwd);
        end
        round_sel = 4'd1; #1; total++;
        if (rk_fwd !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            bad++; $display("FAIL fips_fwd1 got=%h exp=a0fafe1788542cb123a339392a6c7605", rk_fwd);
        end
        model_expand(FIPS_KEY);
        for (int s = 0; s < 16; s++) begin
            @(negedge clk); round_sel = 4'(s); #1;
            exp_inv = '0; exp_fwd = '0;
            if (s <= 10) begin exp_inv = ref_rk[10-s]; exp_fwd = ref_rk[s]; end
            total += 2;
            if (rk_inv !== exp_inv) begin bad++; $display("FAIL fips_sweep_inv sel=%0d got=%h exp=%h", s, rk_inv, exp_inv); end
            if (rk_fwd !== exp_fwd) begin bad++; $display("FAIL fips_sweep_fwd sel=%0d got=%h exp=%h", s, rk_fwd, exp_fwd); end
        end
    endtask

    task automatic test_random_keys();
        int n;
        logic [127:0] key;
        for (int k = 0; k < 4; k++) begin
            key = rand_key();
            @(negedge clk);
            do_load(key);
            wait_valid(n);
            total++;
            if (n != 10) begin bad++; $display("FAIL rand_latency key=%h got=%0d exp=10", key, n); end
            model_expand(key);
            for (int s = 0; s < 16; s++) begin
                @(negedge clk); round_sel = 4'(s); #1;
                exp_inv = '0; exp_fwd = '0;
                if (s <= 10) begin exp_inv = ref_rk[10-s]; exp_fwd = ref_rk[s]; end
                total += 2;
                if (rk_inv !== exp_inv) begin bad++; $display("FAIL rand_inv sel=%0d got=%h exp=%h", s, rk_inv, exp_inv); end
                if (rk_fwd !== exp_fwd) begin bad++; $display("FAIL rand_fwd sel=%0d got=%h exp=%h", s, rk_fwd, exp_fwd); end
            end
        end
    endtask

    task automatic test_restart();
        int n;
        @(negedge clk);
        do_load(rand_key());
        repeat (3) begin
            @(negedge clk);
            total++;
            if (valid_inv !== 1'b0 || busy_inv !== 1'b1) begin
                bad++; $display("FAIL restart_mid valid=%b busy=%b exp valid=0 busy=1", valid_inv, busy_inv);
            end
        end
        do_load('0);
        wait_valid(n);
        total++;
        if (n != 10) begin bad++; $display("FAIL restart_latency got=%0d exp=10", n); end
        round_sel = 4'd1; #1; total++;
        if (rk_fwd !== 128'h62636363626363636263636362636363) begin
            bad++; $display("FAIL restart_rk1 got=%h exp=62636363626363636263636362636363", rk_fwd);
        end
        model_expand('0);
        for (int s = 0; s <= 10; s++) begin
            @(negedge clk); round_sel = 4'(s); #1;
            total++;
            if (rk_fwd !== ref_rk[s]) begin bad++; $display("FAIL restart_sweep sel=%0d got=%h exp=%h", s, rk_fwd, ref_rk[s]); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        do_load(rand_key());
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy_inv !== 1'b0 || valid_inv !== 1'b0) begin
            bad++; $display("FAIL rstmid_flags busy=%b valid=%b exp 0/0", busy_inv, valid_inv);
        end
        // Reset beats a coincident load: no key gets latched and nothing starts.
        reset = 1'b1; key_load = 1'b1; cipher_key = rand_key();
        @(negedge clk);
        reset = 1'b0; key_load = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (busy_inv !== 1'b0 || valid_inv !== 1'b0 || busy_fwd !== 1'b0) begin
                bad++; $display("FAIL rstload_flags busy=%b valid=%b exp 0/0", busy_inv, valid_inv);
            end
        end
        for (int s = 0; s < 16; s++) begin
            @(negedge clk); round_sel = 4'(s); #1;
            total++;
            if (rk_inv !== '0 || rk_fwd !== '0) begin
                bad++; $display("FAIL rstmid_key sel=%0d got=%h/%h exp=0", s, rk_inv, rk_fwd);
            end
        end
    endtask

    task automatic test_reload_from_done();
        int n;
        logic [127:0] key_b;
        @(negedge clk);
        do_load(rand_key());
        wait_valid(n);
        key_b = rand_key();
        do_load(key_b);
        total += 2;
        if (valid_inv !== 1'b0 || valid_fwd !== 1'b0) begin
            bad++; $display("FAIL reload_drop got=%b/%b exp=0", valid_inv, valid_fwd);
        end
        if (busy_inv !== 1'b1) begin bad++; $display("FAIL reload_busy got=%b exp=1", busy_inv); end
        wait_valid(n);
        total++;
        if (n != 10) begin bad++; $display("FAIL reload_latency got=%0d exp=10", n); end
        model_expand(key_b);
        for (int s = 0; s <= 10; s++) begin
            @(negedge clk); round_sel = 4'(s); #1;
            total++;
            if (rk_inv !== ref_rk[10-s]) begin bad++; $display("FAIL reload_sweep sel=%0d got=%h exp=%h", s, rk_inv, ref_rk[10-s]); end
        end
    endtask

    task automatic test_held_load();
        int n;
        logic [127:0] key_c;
        key_c = rand_key();
        @(negedge clk);
        key_load = 1'b1; cipher_key = rand_key();
        @(negedge clk);
        cipher_key = rand_key();
        @(negedge clk);
        do_load(key_c);
        wait_valid(n);
        total++;
        if (n != 10) begin bad++; $display("FAIL held_latency got=%0d exp=10", n); end
        model_expand(key_c);
        for (int s = 0; s <= 10; s++) begin
            @(negedge clk); round_sel = 4'(s); #1;
            total++;
            if (rk_fwd !== ref_rk[s]) begin bad++; $display("FAIL held_sweep sel=%0d got=%h exp=%h", s, rk_fwd, ref_rk[s]); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fips();
        test_random_keys();
        test_restart();
        test_reset_mid();
        test_reload_from_done();
        test_held_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Round-key generator and store for the AES-128 datapath. On a load pulse it expands a 128-bit cipher key into the 11 round keys, one key per clock, and holds them in an internal register bank. It sits upstream of the decryption round datapath. The round-select index that the decryption controller drives to the round-key mux selects which stored key is presented. The top level holds the decryption `start` until `key_valid` is high.

## Interface
Parameters:
- `INVERSE_ORDER`, default 1: 1 → `round_key = rk[10 - round_sel]` (decryption order); 0 → `round_key = rk[round_sel]` (encryption order).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `key_load`  in  1  one-cycle pulse; latch `cipher_key` and start expansion.
- `cipher_key`  in  128  cipher key; bits [127:96] are w0, [31:0] are w3. Sampled only on the `key_load` cycle.
- `round_sel`  in  4  round index 0..10 from the decryption controller.
- `round_key`  out  128  selected round key; combinational read of the registered bank.
- `key_valid`  out  1  high when all 11 keys are stored and consistent.
- `busy`  out  1  high while expansion is in progress.

## Operation
- Storage: `rk[0..10]`, 128 bits each. 4-bit round counter `r`. States IDLE, EXPAND, DONE.
- IDLE → EXPAND on `key_load`:
  - `rk[0] <= cipher_key`, `r <= 1`.
  - `key_valid <= 0`, `busy <= 1`.
- EXPAND: each cycle, write `rk[r]` computed from `rk[r-1]` (words p0..p3):
  - `t = SubWord(RotWord(p3)) ^ {rcon[r], 24'h0}`.
  - `q0 = p0 ^ t`, `q1 = q0 ^ p1`, `q2 = q1 ^ p2`, `q3 = q2 ^ p3`.
  - `r <= r + 1`.
- RotWord: {b0,b1,b2,b3} → {b1,b2,b3,b0}. SubWord: four forward AES S-box lookups, combinational.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex).
- Expansion end: the cycle that writes `rk[10]` also moves to DONE, with `key_valid <= 1`, `busy <= 0`.
- DONE: keys held indefinitely. `key_load` restarts exactly as from IDLE.
- `key_load` during EXPAND: abort the current expansion and restart with the new `cipher_key`. No partial result is ever flagged valid.
- Read path:
  - `round_sel` 0..10 → key index per `INVERSE_ORDER`.
  - `round_sel` 11..15 → `round_key = 128'h0`.
  - The read path is independent of state. During EXPAND it shows whatever is currently stored; consumers must qualify reads with `key_valid`.
- All arithmetic is GF(2) XOR and table lookup. No carries, no widths beyond 32-bit words.

## Timing
- Reset (synchronous, on the edge where `reset`=1):
  - State IDLE, `r = 0`, all `rk` = 0.
  - `key_valid = 0`, `busy = 0`.
  - `round_key = 0` for every `round_sel`.
- Reset mid-expansion: same as above, aborts immediately. It takes priority over a simultaneous `key_load`.
- `key_load` sampled at edge t:
  - `rk[0]` and `busy = 1` visible after t.
  - `rk[k]` written at edge t+k.
  - `key_valid = 1` and `busy = 0` visible after edge t+10.
  - Total: 11 edges including the load.
- `key_valid` falls after the edge that samples `key_load`, even when the state is DONE.
- `round_key` follows `round_sel` with zero latency, purely combinational from registers.
- `key_load` held high for several cycles: each cycle is treated as a restart. Expansion begins after the last high cycle.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `key_load` pulse, `INVERSE_ORDER`=1:
  - `key_valid` rises exactly 10 cycles after the load edge.
  - `round_sel`=0 → `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `round_sel`=9 → `a0fafe1788542cb123a339392a6c7605`.
  - `round_sel`=10 → the cipher key.
- Same key with `INVERSE_ORDER`=0: `round_sel`=1 → `a0fafe17…2a6c7605`; `round_sel`=10 → `d014f9a8…b6630ca6`. Sweep 0..10 against a reference model.
- Out-of-range select: `round_sel`=11 and 15 → `round_key` = 0, in both IDLE and DONE.
- Restart: `key_load` with key A, then a second `key_load` with the all-zero key 4 cycles later:
  - `key_valid` stays 0 until 10 cycles after the second load.
  - Final keys match the zero-key schedule, e.g. rk[1] = `62636363626363636263636362636363`.
- Reset mid-expansion: assert `reset` 5 cycles after load:
  - Next cycle: `busy` = 0, `key_valid` = 0, all round keys read 0.
  - `reset` and `key_load` asserted in the same cycle → stays IDLE.
- Reload from DONE: after valid key A, load key B:
  - `key_valid` drops the next cycle and `busy` rises.
  - `key_valid` reasserts 10 cycles after the load with B's schedule.
